// File: rtl/axi_rd_arbiter.sv
// Read-path arbiter for a 2-master / 2-slave AXI interconnect.
// Round-robin grant, slave decode from one address bit, and one outstanding
// burst; the grant is held until the RLAST beat completes its handshake.
module axi_rd_arbiter #(
    parameter int unsigned SEL_BIT   = 16,
    parameter int unsigned ADDR_BITS = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic                 ARVALID_M0,
    input  logic                 ARVALID_M1,
    input  logic [ADDR_BITS-1:0] ARADDR_M0,
    input  logic [ADDR_BITS-1:0] ARADDR_M1,
    output logic                 ARREADY_M0,
    output logic                 ARREADY_M1,
    output logic                 ARVALID_S0,
    output logic                 ARVALID_S1,
    input  logic                 ARREADY_S0,
    input  logic                 ARREADY_S1,
    input  logic                 RVALID_S0,
    input  logic                 RVALID_S1,
    input  logic                 RLAST_S0,
    input  logic                 RLAST_S1,
    output logic                 RREADY_S0,
    output logic                 RREADY_S1,
    output logic                 RVALID_M0,
    output logic                 RVALID_M1,
    input  logic                 RREADY_M0,
    input  logic                 RREADY_M1,
    output logic [1:0]           ar_gnt,
    output logic                 r_mst,
    output logic                 r_slv,
    output logic                 busy
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e state_q, state_d;
    logic   prio_q, prio_d;
    logic   mst_q, mst_d;
    logic   slv_q, slv_d;

    logic [1:0] arvalid_m, arready_s, rvalid_s, rlast_s, rready_m;
    logic [1:0] arready_m, arvalid_s, rready_s, rvalid_m;
    logic       winner;
    logic       ar_hs;
    logic       r_last_hs;

    // Only the select bit of each address is decoded.
    logic unused_addr;
    assign unused_addr = ^{ARADDR_M0, ARADDR_M1};

    assign arvalid_m = {ARVALID_M1, ARVALID_M0};
    assign arready_s = {ARREADY_S1, ARREADY_S0};
    assign rvalid_s  = {RVALID_S1, RVALID_S0};
    assign rlast_s   = {RLAST_S1, RLAST_S0};
    assign rready_m  = {RREADY_M1, RREADY_M0};

    assign ar_hs     = (state_q == StAddr) & arvalid_m[mst_q] & arready_s[slv_q];
    assign r_last_hs = (state_q == StData) & rvalid_s[slv_q] & rready_m[mst_q] & rlast_s[slv_q];

    // Contention goes to prio; a lone requester always wins.
    assign winner = (ARVALID_M0 & ARVALID_M1) ? prio_q : ARVALID_M1;

    // Next-state: arbitrate in idle, advance on AR handshake and on the RLAST beat.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        mst_d   = mst_q;
        slv_d   = slv_q;
        unique case (state_q)
            StIdle: begin
                if (ARVALID_M0 | ARVALID_M1) begin
                    mst_d   = winner;
                    slv_d   = winner ? ARADDR_M1[SEL_BIT] : ARADDR_M0[SEL_BIT];
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (ar_hs) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (r_last_hs) begin
                    state_d = StIdle;
                    prio_d  = ~mst_q;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= StIdle;
            prio_q  <= 1'b0;
            mst_q   <= 1'b0;
            slv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            mst_q   <= mst_d;
            slv_q   <= slv_d;
        end
    end

    // Handshake routing: only the granted master/selected slave pair is connected.
    always_comb begin
        arready_m = 2'b00;
        arvalid_s = 2'b00;
        rready_s  = 2'b00;
        rvalid_m  = 2'b00;
        ar_gnt    = 2'b00;
        unique case (state_q)
            StAddr: begin
                ar_gnt[mst_q]    = 1'b1;
                arvalid_s[slv_q] = arvalid_m[mst_q];
                arready_m[mst_q] = arready_s[slv_q];
            end
            StData: begin
                rvalid_m[mst_q] = rvalid_s[slv_q];
                rready_s[slv_q] = rready_m[mst_q];
            end
            default: ;
        endcase
    end

    assign ARREADY_M0 = arready_m[0];
    assign ARREADY_M1 = arready_m[1];
    assign ARVALID_S0 = arvalid_s[0];
    assign ARVALID_S1 = arvalid_s[1];
    assign RREADY_S0  = rready_s[0];
    assign RREADY_S1  = rready_s[1];
    assign RVALID_M0  = rvalid_m[0];
    assign RVALID_M1  = rvalid_m[1];
    assign r_mst      = mst_q;
    assign r_slv      = slv_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a per-cycle vector table followed by a
// hand-written sequence covering arbitration latency and a stalled slave.
module tb_axi_rd_arbiter;

    logic        clk = 1'b0;
    logic        ARESET;
    logic        ARVALID_M0, ARVALID_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic        ARREADY_M0, ARREADY_M1;
    logic        ARVALID_S0, ARVALID_S1;
    logic        ARREADY_S0, ARREADY_S1;
    logic        RVALID_S0, RVALID_S1, RLAST_S0, RLAST_S1;
    logic        RREADY_S0, RREADY_S1;
    logic        RVALID_M0, RVALID_M1;
    logic        RREADY_M0, RREADY_M1;
    logic [1:0]  ar_gnt;
    logic        r_mst, r_slv, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.SEL_BIT(16), .ADDR_BITS(32)) dut (
        .ACLK       (clk),
        .ARESET     (ARESET),
        .ARVALID_M0 (ARVALID_M0),
        .ARVALID_M1 (ARVALID_M1),
        .ARADDR_M0  (ARADDR_M0),
        .ARADDR_M1  (ARADDR_M1),
        .ARREADY_M0 (ARREADY_M0),
        .ARREADY_M1 (ARREADY_M1),
        .ARVALID_S0 (ARVALID_S0),
        .ARVALID_S1 (ARVALID_S1),
        .ARREADY_S0 (ARREADY_S0),
        .ARREADY_S1 (ARREADY_S1),
        .RVALID_S0  (RVALID_S0),
        .RVALID_S1  (RVALID_S1),
        .RLAST_S0   (RLAST_S0),
        .RLAST_S1   (RLAST_S1),
        .RREADY_S0  (RREADY_S0),
        .RREADY_S1  (RREADY_S1),
        .RVALID_M0  (RVALID_M0),
        .RVALID_M1  (RVALID_M1),
        .RREADY_M0  (RREADY_M0),
        .RREADY_M1  (RREADY_M1),
        .ar_gnt     (ar_gnt),
        .r_mst      (r_mst),
        .r_slv      (r_slv),
        .busy       (busy)
    );

    // Bit [0] is M0/S0, bit [1] is M1/S1. sel is ARADDR_Mx[16].
    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] arv_m, sel, arr_s, rv_s, rl_s, rr_m;
        logic [1:0] e_arr_m, e_arv_s, e_rr_s, e_rv_m, e_gnt;
        logic       e_mst, e_slv, e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input string name, input logic rst,
        input logic [1:0] arv_m, input logic [1:0] sel, input logic [1:0] arr_s,
        input logic [1:0] rv_s, input logic [1:0] rl_s, input logic [1:0] rr_m,
        input logic [1:0] e_arr_m, input logic [1:0] e_arv_s, input logic [1:0] e_rr_s,
        input logic [1:0] e_rv_m, input logic [1:0] e_gnt,
        input logic e_mst, input logic e_slv, input logic e_busy);
        vec_t v;
        v.name = name; v.rst = rst;
        v.arv_m = arv_m; v.sel = sel; v.arr_s = arr_s;
        v.rv_s = rv_s; v.rl_s = rl_s; v.rr_m = rr_m;
        v.e_arr_m = e_arr_m; v.e_arv_s = e_arv_s; v.e_rr_s = e_rr_s;
        v.e_rv_m = e_rv_m; v.e_gnt = e_gnt;
        v.e_mst = e_mst; v.e_slv = e_slv; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Non-select address bits carry a fixed pattern so only bit 16 matters.
    task automatic drive(input logic rst, input logic [1:0] arv_m, input logic [1:0] sel,
                         input logic [1:0] arr_s, input logic [1:0] rv_s,
                         input logic [1:0] rl_s, input logic [1:0] rr_m);
        ARESET     = rst;
        ARVALID_M0 = arv_m[0];
        ARVALID_M1 = arv_m[1];
        ARADDR_M0  = 32'h00A2_BEEF | (32'(sel[0]) << 16);
        ARADDR_M1  = 32'h00A2_BEEF | (32'(sel[1]) << 16);
        ARREADY_S0 = arr_s[0];
        ARREADY_S1 = arr_s[1];
        RVALID_S0  = rv_s[0];
        RVALID_S1  = rv_s[1];
        RLAST_S0   = rl_s[0];
        RLAST_S1   = rl_s[1];
        RREADY_M0  = rr_m[0];
        RREADY_M1  = rr_m[1];
    endtask

    initial begin
        int beats;
        int waited;
        bit seen;

        //                     rst arv   sel   arr   rv    rl    rr   | arr_m arv_s rr_s  rv_m  gnt   m  s  b
        vecs.push_back(mk("rst_hold",     1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk("idle_both",    0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk("m0_ar_wait",   0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 1));
        vecs.push_back(mk("m0_ar_hs",     0, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 1));
        vecs.push_back(mk("m0_beat1",     0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 1));
        vecs.push_back(mk("m0_bp1",       0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 1));
        vecs.push_back(mk("m0_bp2",       0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 1));
        vecs.push_back(mk("m0_bp3",       0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 0, 0, 1));
        vecs.push_back(mk("m0_isolate",   0, 2'b10, 2'b00, 2'b00, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 1));
        vecs.push_back(mk("m0_last",      0, 2'b10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 1));
        vecs.push_back(mk("m1_idle",      0, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk("m1_ar_wait",   0, 2'b10, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 1, 1, 1));
        vecs.push_back(mk("m1_ar_hs",     0, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 1, 1, 1));
        vecs.push_back(mk("m1_beat1",     0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 1, 1, 1));
        vecs.push_back(mk("m1_beat2",     0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 1, 1, 1));
        vecs.push_back(mk("m1_beat3",     0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 1, 1, 1));
        vecs.push_back(mk("m1_last",      0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 1, 1, 1));
        vecs.push_back(mk("cont_idle1",   0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0));
        vecs.push_back(mk("cont_m0_ar",   0, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 1));
        vecs.push_back(mk("cont_m0_last", 0, 2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 1));
        vecs.push_back(mk("cont_idle2",   0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk("cont_m1_ar",   0, 2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 1, 1, 1));
        vecs.push_back(mk("cont_m1_last", 0, 2'b11, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 1, 1, 1));
        vecs.push_back(mk("cont_idle3",   0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0));
        vecs.push_back(mk("cont_m0_again",0, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 1));
        vecs.push_back(mk("m0_ar_hs2",    0, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 0, 0, 1));
        vecs.push_back(mk("rst_in_data",  1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, 1));
        vecs.push_back(mk("post_rst",     0, 2'b10, 2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0));
        vecs.push_back(mk("post_rst_ar",  0, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 1, 1, 1));
        vecs.push_back(mk("post_rst_last",0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 1, 1, 1));
        vecs.push_back(mk("post_idle",    0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0));

        // Bring state out of X before the table starts.
        drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        repeat (2) @(posedge clk);

        // Inputs change on the falling edge; outputs sampled 1ns later.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].arv_m, vecs[i].sel, vecs[i].arr_s,
                  vecs[i].rv_s, vecs[i].rl_s, vecs[i].rr_m);
            #1;
            chk({vecs[i].name, ".arready_m"}, {ARREADY_M1, ARREADY_M0}, vecs[i].e_arr_m);
            chk({vecs[i].name, ".arvalid_s"}, {ARVALID_S1, ARVALID_S0}, vecs[i].e_arv_s);
            chk({vecs[i].name, ".rready_s"},  {RREADY_S1, RREADY_S0},   vecs[i].e_rr_s);
            chk({vecs[i].name, ".rvalid_m"},  {RVALID_M1, RVALID_M0},   vecs[i].e_rv_m);
            chk({vecs[i].name, ".ar_gnt"},    ar_gnt,                   vecs[i].e_gnt);
            chk({vecs[i].name, ".r_mst"},     {1'b0, r_mst},            {1'b0, vecs[i].e_mst});
            chk({vecs[i].name, ".r_slv"},     {1'b0, r_slv},            {1'b0, vecs[i].e_slv});
            chk({vecs[i].name, ".busy"},      {1'b0, busy},             {1'b0, vecs[i].e_busy});
        end

        // Sequence: M0 to S1, grant one cycle after request, S1 stalls AR.
        @(negedge clk);
        drive(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
        #1;
        chk("seq.req_cycle_gnt", ar_gnt, 2'b00);
        @(negedge clk);
        #1;
        chk("seq.gnt_next", ar_gnt, 2'b01);
        chk("seq.arvalid_s", {ARVALID_S1, ARVALID_S0}, 2'b10);
        chk("seq.r_slv", {1'b0, r_slv}, 2'b01);
        chk("seq.arready_stall", {ARREADY_M1, ARREADY_M0}, 2'b00);

        // S1 becomes ready after two more cycles; bounded wait for ARREADY_M0.
        seen = 1'b0;
        waited = 0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(negedge clk);
            ARREADY_S1 = (c >= 2);
            #1;
            if (ARREADY_M0) begin
                seen = 1'b1;
                waited = c;
            end
        end
        chk("seq.ar_seen", {1'b0, seen}, 2'b01);
        chk("seq.ar_wait_cycles", 2'(waited), 2'd2);

        // Two-beat burst; S0 noise must not leak into the routed channel.
        beats = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b11, {c == 1, 1'b1}, 2'b11);
            #1;
            chk("seq.rvalid_m", {RVALID_M1, RVALID_M0}, 2'b01);
            chk("seq.rready_s", {RREADY_S1, RREADY_S0}, 2'b10);
            if (RVALID_M0 && RREADY_S1) beats++;
        end
        chk("seq.beats", 2'(beats), 2'd2);

        @(negedge clk);
        drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        #1;
        chk("seq.idle_after_last", {1'b0, busy}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
